// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button front end.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    RELEASE_DB
  } btn_state_t;

  localparam int unsigned DB_MS_DEF     = 20;
  localparam int unsigned LONG_MS_DEF   = 800;
  localparam int unsigned REPEAT_MS_DEF = 200;
  localparam int unsigned CNT_W_DEF     = 10;

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer with synchronous active-high reset, for any board button.
module btn_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_press_classifier.sv
// Debounces one raw button and classifies presses as short or long.
// Define BUTTON_AUTO_REPEAT_EN to emit inc_short every REPEAT_MS ticks while in LONG.
module button_press_classifier
  import button_pkg::*;
#(
  parameter int unsigned DB_MS     = DB_MS_DEF,
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_ms,
  input  logic btn_raw,
  output logic pressed,
  output logic inc_short,
  output logic long_pulse,
  output logic long_hold
);

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DB_MS - 1);
  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_MS - DB_MS - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

  logic             btn_s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] rcnt;
  logic             ret_long;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RepLast = CNT_W'(REPEAT_MS - 1);
  logic [CNT_W-1:0] rep_cnt;
`endif

  btn_sync u_btn_sync (
    .clk_i (clk),
    .rst_i (rst),
    .d_i   (btn_raw),
    .q_o   (btn_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rcnt       <= '0;
      ret_long   <= 1'b0;
      pressed    <= 1'b0;
      inc_short  <= 1'b0;
      long_pulse <= 1'b0;
      long_hold  <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      inc_short  <= 1'b0;
      long_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_s) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (tick_ms) begin
            if (cnt == DbLast) begin
              state   <= HELD;
              cnt     <= '0;
              pressed <= 1'b1;
            end else begin
              cnt <= cnt + CntOne;
            end
          end
        end
        // Release is checked first so it wins over a coincident long threshold.
        HELD: begin
          if (!btn_s) begin
            state    <= RELEASE_DB;
            ret_long <= 1'b0;
            rcnt     <= '0;
          end else if (tick_ms) begin
            if (cnt == LongLast) begin
              state      <= LONG;
              cnt        <= '0;
              long_pulse <= 1'b1;
              long_hold  <= 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end else begin
              cnt <= cnt + CntOne;
            end
          end
        end
        LONG: begin
          if (!btn_s) begin
            state    <= RELEASE_DB;
            ret_long <= 1'b1;
            rcnt     <= '0;
          end
`ifdef BUTTON_AUTO_REPEAT_EN
          else if (tick_ms) begin
            if (rep_cnt == RepLast) begin
              rep_cnt   <= '0;
              inc_short <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + CntOne;
            end
          end
`endif
        end
        // cnt (and rep_cnt) stay frozen here so a release glitch resumes timing.
        RELEASE_DB: begin
          if (btn_s) begin
            state <= ret_long ? LONG : HELD;
          end else if (tick_ms) begin
            if (rcnt == DbLast) begin
              state     <= IDLE;
              cnt       <= '0;
              rcnt      <= '0;
              pressed   <= 1'b0;
              long_hold <= 1'b0;
              inc_short <= !ret_long;
            end else begin
              rcnt <= rcnt + CntOne;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_classifier.sv
// Scoreboard bench: expected events (with cycle stamps) are queued as stimulus is driven.
module tb_button_press_classifier;
  import button_pkg::*;

  localparam int DB  = 4;
  localparam int LNG = 16;
  localparam int REP = 4;

  localparam int EvRise = 1;
  localparam int EvLong = 2;
  localparam int EvInc  = 3;
  localparam int EvFall = 4;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic tick_ms;
  logic btn_raw;
  logic pressed;
  logic inc_short;
  logic long_pulse;
  logic long_hold;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  ev_t  sb[$];
  logic pressed_prev = 1'b0;

  button_press_classifier #(
    .DB_MS     (DB),
    .LONG_MS   (LNG),
    .REPEAT_MS (REP),
    .CNT_W     (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_ms    (tick_ms),
    .btn_raw    (btn_raw),
    .pressed    (pressed),
    .inc_short  (inc_short),
    .long_pulse (long_pulse),
    .long_hold  (long_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    if (sb.size() == 0) begin
      check("spurious_event", kind, 0);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.cyc);
    end
  endtask

  // Sample on the falling edge: outputs reflect rising edge number cyc.
  always @(negedge clk) begin
    if (pressed === 1'b1 && pressed_prev === 1'b0) got_event(EvRise);
    if (long_pulse === 1'b1) got_event(EvLong);
    if (inc_short === 1'b1) got_event(EvInc);
    if (pressed === 1'b0 && pressed_prev === 1'b1) got_event(EvFall);
    if (inc_short === 1'b1 && long_pulse === 1'b1) check("pulse_overlap", 1, 0);
    pressed_prev <= pressed;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  // Clean press held for hold clocks; expected events derived from the timing rules.
  task automatic run_press(input int hold);
    int start, see, r, lng;
    bit is_long;
    start   = cyc;
    btn_raw = 1'b1;
    see     = start + 3;
    r       = start + hold + 3;
    lng     = see + LNG;
    is_long = (lng < r);
    push(EvRise, see + DB);
    if (is_long) begin
      push(EvLong, lng);
`ifdef BUTTON_AUTO_REPEAT_EN
      for (int t = lng + REP; t < r; t += REP) push(EvInc, t);
`endif
    end else begin
      push(EvInc, r + DB);
    end
    push(EvFall, r + DB);
    repeat (hold) step();
    check("hold_mid_long_hold", int'(long_hold), int'(lng <= cyc));
    btn_raw = 1'b0;
    wait_cyc(r + DB - 1);
    check("hold_before_end", int'(long_hold), int'(is_long));
    check("pressed_before_end", int'(pressed), 1);
    wait_cyc(r + DB);
    check("hold_after_end", int'(long_hold), 0);
    check("pressed_after_end", int'(pressed), 0);
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst     = 1'b1;
    tick_ms = 1'b1;
    btn_raw = 1'b0;
    repeat (3) step();
    check("rst_pressed", int'(pressed), 0);
    check("rst_inc_short", int'(inc_short), 0);
    check("rst_long_pulse", int'(long_pulse), 0);
    check("rst_long_hold", int'(long_hold), 0);
    check("rst_state", int'(dut.state), int'(IDLE));
    rst = 1'b0;
    repeat (2) step();

    run_press(10);
    run_press(40);
    run_press(16);
    run_press(17);

    // Bounce: two short pulses never complete the press debounce.
    btn_raw = 1'b1; repeat (2) step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; repeat (2) step();
    btn_raw = 1'b0; repeat (8) step();
    check("bounce_state", int'(dut.state), int'(IDLE));
    check("bounce_pressed", int'(pressed), 0);

    // Release glitch inside HELD: one short press, cnt resumes.
    s = cyc;
    push(EvRise, s + 7);
    push(EvInc, s + 21);
    push(EvFall, s + 21);
    btn_raw = 1'b1; repeat (10) step();
    btn_raw = 1'b0; step();
    btn_raw = 1'b1; repeat (3) step();
    btn_raw = 1'b0;
    wait_cyc(s + 20);
    check("glitch_pressed_held", int'(pressed), 1);
    wait_cyc(s + 21);
    check("glitch_pressed_end", int'(pressed), 0);
    repeat (3) step();

    // No ticks: the press debounce never completes.
    tick_ms = 1'b0;
    btn_raw = 1'b1; repeat (20) step();
    check("notick_pressed", int'(pressed), 0);
    check("notick_state", int'(dut.state), int'(PRESS_DB));
    btn_raw = 1'b0; repeat (5) step();
    tick_ms = 1'b1;
    check("notick_idle", int'(dut.state), int'(IDLE));

    // Reset mid-HELD aborts the press without an event.
    s = cyc;
    push(EvRise, s + 7);
    push(EvFall, s + 11);
    btn_raw = 1'b1;
    repeat (10) step();
    check("pre_rst_pressed", int'(pressed), 1);
    rst     = 1'b1;
    btn_raw = 1'b0;
    step();
    check("midrst_pressed", int'(pressed), 0);
    check("midrst_long_hold", int'(long_hold), 0);
    check("midrst_inc_short", int'(inc_short), 0);
    check("midrst_state", int'(dut.state), int'(IDLE));
    step();
    rst = 1'b0;
    repeat (20) step();

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
